// File: rtl/forw_unit_sb.sv
// Forwarding/interlock controller: tracks DEPTH in-flight destination tags and
// picks, per read port, the youngest producer or raises a load-use stall.

module forw_port_match #(
  parameter int REG_W = 5,
  parameter int DEPTH = 2,
  parameter int SEL_W = 2
) (
  input  logic [REG_W-1:0]            rs,
  input  logic                        used,
  input  logic [DEPTH:1]              hit_v,
  input  logic [DEPTH:1][REG_W-1:0]   rd,
  input  logic [DEPTH:1][SEL_W-1:0]   rdy,
  output logic [SEL_W-1:0]            sel,
  output logic                        hazard
);
  // Walk oldest to youngest so the youngest match overrides, even if not ready.
  always_comb begin
    sel    = '0;
    hazard = 1'b0;
    if (used && rs != '0) begin
      for (int k = DEPTH; k >= 1; k--) begin
        if (hit_v[k] && rd[k] == rs) begin
          if (SEL_W'(k) >= rdy[k]) begin
            sel    = SEL_W'(k);
            hazard = 1'b0;
          end else begin
            sel    = '0;
            hazard = 1'b1;
          end
        end
      end
    end
  end
endmodule

module forw_unit_sb #(
  parameter int REG_W = 5,
  parameter int N_RD  = 2,
  parameter int DEPTH = 2,
  parameter int CNT_W = 32,
  parameter int SEL_W = $clog2(DEPTH+1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [N_RD*REG_W-1:0]   id_rs,
  input  logic [N_RD-1:0]         id_rs_used,
  input  logic                    id_we,
  input  logic [REG_W-1:0]        id_rd,
  input  logic [SEL_W-1:0]        id_rdy,
  input  logic                    ex_flush,
  output logic [N_RD*SEL_W-1:0]   sel,
  output logic                    stall,
  output logic [CNT_W-1:0]        stall_cnt
);
  typedef struct packed {
    logic             we;
    logic [REG_W-1:0] rd;
    logic [SEL_W-1:0] rdy;
  } tag_t;

  logic [DEPTH:1]              vld_pipe;
  tag_t [DEPTH:1]              tags;
  tag_t                        cap;
  logic [DEPTH:1]              hit_v;
  logic [DEPTH:1][REG_W-1:0]   tag_rd;
  logic [DEPTH:1][SEL_W-1:0]   tag_rdy;
  logic [N_RD-1:0][SEL_W-1:0]  sel_raw;
  logic [N_RD-1:0]             hazard;

  for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
    assign hit_v[k]   = vld_pipe[k] & tags[k].we;
    assign tag_rd[k]  = tags[k].rd;
    assign tag_rdy[k] = tags[k].rdy;
  end

  for (genvar p = 0; p < N_RD; p++) begin : g_port
    forw_port_match #(.REG_W(REG_W), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_match (
      .rs     (id_rs[p*REG_W +: REG_W]),
      .used   (id_rs_used[p]),
      .hit_v  (hit_v),
      .rd     (tag_rd),
      .rdy    (tag_rdy),
      .sel    (sel_raw[p]),
      .hazard (hazard[p])
    );
  end

  // Outputs are forced quiet while reset is held, whatever the stale state.
  assign sel   = rst ? '0 : sel_raw;
  assign stall = id_valid & (|hazard) & ~rst;

  // x0 never produces; ready stage is clamped into 1..DEPTH.
  always_comb begin
    cap.we  = id_we && (id_rd != '0);
    cap.rd  = id_rd;
    cap.rdy = id_rdy;
    if (id_rdy == '0)                 cap.rdy = SEL_W'(1);
    else if (id_rdy > SEL_W'(DEPTH))  cap.rdy = SEL_W'(DEPTH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      tags      <= '0;
      stall_cnt <= '0;
    end else begin
      vld_pipe[1] <= id_valid & ~stall & ~ex_flush;
      tags[1]     <= cap;
      for (int k = 2; k <= DEPTH; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        tags[k]     <= tags[k-1];
      end
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_forw_unit_sb.sv
// Directed bench: a queue-based pipeline history model checked every cycle,
// plus literal expectations at the interesting points.

module tb_forw_unit_sb;
  localparam int REG_W = 5, N_RD = 2, DEPTH = 2, SEL_W = 2;

  bit clk;
  logic rst, id_valid, id_we, ex_flush;
  logic [N_RD*REG_W-1:0] id_rs;
  logic [N_RD-1:0]       id_rs_used;
  logic [REG_W-1:0]      id_rd;
  logic [SEL_W-1:0]      id_rdy;
  logic [N_RD*SEL_W-1:0] sel, sel_s;
  logic                  stall, stall_s;
  logic [31:0]           stall_cnt;
  logic [3:0]            sat_cnt;

  forw_unit_sb #(.REG_W(REG_W), .N_RD(N_RD), .DEPTH(DEPTH), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_we(id_we), .id_rd(id_rd), .id_rdy(id_rdy), .ex_flush(ex_flush),
    .sel(sel), .stall(stall), .stall_cnt(stall_cnt));

  forw_unit_sb #(.REG_W(REG_W), .N_RD(N_RD), .DEPTH(DEPTH), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_we(id_we), .id_rd(id_rd), .id_rdy(id_rdy), .ex_flush(ex_flush),
    .sel(sel_s), .stall(stall_s), .stall_cnt(sat_cnt));

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;

  task automatic cmp(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: history of what left decode, index 0 = one cycle ago.
  typedef struct { bit v; bit we; int rd; int rdy; } rec_t;
  rec_t hist[$];
  int   mcnt = 0;
  int   e_sel[N_RD];
  bit   e_stall;

  function automatic void mdl_eval();
    bit hz = 0;
    for (int p = 0; p < N_RD; p++) begin
      int rs;
      e_sel[p] = 0;
      rs = int'(id_rs[p*REG_W +: REG_W]);
      if (rst || !id_rs_used[p] || rs == 0) continue;
      for (int k = 0; k < hist.size(); k++) begin
        if (hist[k].v && hist[k].we && hist[k].rd == rs) begin
          if (k + 1 >= hist[k].rdy) e_sel[p] = k + 1;
          else hz = 1;
          break;
        end
      end
    end
    e_stall = !rst && id_valid && hz;
  endfunction

  initial for (int i = 0; i < DEPTH; i++) hist.push_back('{0, 0, 0, 1});

  always @(posedge clk) begin
    rec_t r;
    mdl_eval();
    if (rst) begin
      foreach (hist[i]) hist[i].v = 0;
      mcnt = 0;
    end else begin
      if (e_stall) mcnt++;
      r.v   = id_valid && !e_stall && !ex_flush;
      r.we  = id_we && id_rd != 0;
      r.rd  = int'(id_rd);
      r.rdy = (id_rdy == 0) ? 1 : (int'(id_rdy) > DEPTH ? DEPTH : int'(id_rdy));
      hist.push_front(r);
      if (hist.size() > DEPTH) void'(hist.pop_back());
    end
  end

  always @(negedge clk) begin
    mdl_eval();
    for (int p = 0; p < N_RD; p++)
      cmp($sformatf("sel%0d", p), int'(sel[p*SEL_W +: SEL_W]), e_sel[p]);
    cmp("stall", int'(stall), int'(e_stall));
    cmp("stall_sat", int'(stall_s), int'(e_stall));
    cmp("stall_cnt", int'(stall_cnt), mcnt);
    cmp("sat_cnt", int'(sat_cnt), mcnt > 15 ? 15 : mcnt);
  end

  task automatic drv(input bit v, input int rs0, input int rs1, input bit [1:0] used,
                     input bit we, input int rd, input int rdy, input bit fl);
    id_valid   = v;
    id_rs      = {REG_W'(rs1), REG_W'(rs0)};
    id_rs_used = used;
    id_we      = we;
    id_rd      = REG_W'(rd);
    id_rdy     = SEL_W'(rdy);
    ex_flush   = fl;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1;
    drv(1, 5, 5, 2'b11, 1, 5, 1, 0);
    cmp("rst_sel", int'(sel), 0);
    cmp("rst_stall", int'(stall), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
    // ALU chain
    drv(1, 5, 5, 2'b11, 1, 5, 1, 0);
    cmp("post_rst_sel", int'(sel), 0);
    cmp("post_rst_cnt", int'(stall_cnt), 0);
    tick();
    drv(1, 5, 0, 2'b01, 0, 0, 1, 0);
    cmp("alu_1d", int'(sel[1:0]), 1);
    tick();
    drv(1, 0, 5, 2'b10, 0, 0, 1, 0);
    cmp("alu_2d", int'(sel[3:2]), 2);
    cmp("alu_2d_stall", int'(stall), 0);
    tick();
    // x0 and unused ports
    drv(1, 0, 0, 2'b00, 1, 0, 1, 0);
    tick();
    drv(1, 0, 0, 2'b01, 1, 6, 1, 0);
    cmp("x0_sel", int'(sel[1:0]), 0);
    tick();
    drv(1, 0, 6, 2'b01, 0, 0, 1, 0);
    cmp("unused_sel", int'(sel[3:2]), 0);
    cmp("unused_stall", int'(stall), 0);
    tick();
    // load-use
    drv(1, 0, 0, 2'b00, 1, 7, 2, 0);
    tick();
    drv(1, 7, 0, 2'b01, 0, 0, 1, 0);
    cmp("ld_stall", int'(stall), 1);
    cmp("ld_sel", int'(sel[1:0]), 0);
    tick();
    cmp("ld_after_stall", int'(stall), 0);
    cmp("ld_after_sel", int'(sel[1:0]), 2);
    cmp("ld_after_cnt", int'(stall_cnt), 1);
    tick();
    // priority
    drv(1, 0, 0, 2'b00, 1, 3, 1, 0);
    tick();
    drv(1, 0, 0, 2'b00, 1, 3, 1, 0);
    tick();
    drv(1, 3, 0, 2'b01, 1, 3, 2, 0);
    cmp("prio_young", int'(sel[1:0]), 1);
    tick();
    drv(1, 3, 0, 2'b01, 0, 0, 1, 0);
    cmp("prio_stall", int'(stall), 1);
    tick();
    cmp("prio_after", int'(sel[1:0]), 2);
    tick();
    // flush
    drv(1, 0, 0, 2'b00, 1, 4, 1, 1);
    tick();
    drv(1, 4, 0, 2'b01, 0, 0, 1, 0);
    cmp("flush_sel", int'(sel[1:0]), 0);
    cmp("flush_stall", int'(stall), 0);
    tick();
    // stall together with flush
    drv(1, 0, 0, 2'b00, 1, 8, 2, 0);
    tick();
    drv(1, 8, 0, 2'b01, 0, 0, 1, 1);
    cmp("stfl_stall", int'(stall), 1);
    tick();
    drv(1, 8, 0, 2'b01, 0, 0, 1, 0);
    tick();
    // reset mid-stall
    drv(1, 0, 0, 2'b00, 1, 9, 2, 0);
    tick();
    drv(1, 9, 0, 2'b01, 0, 0, 1, 0);
    cmp("mid_stall", int'(stall), 1);
    tick();
    rst = 1;
    drv(1, 9, 0, 2'b01, 0, 0, 1, 0);
    cmp("mid_rst_stall", int'(stall), 0);
    tick();
    rst = 0;
    drv(1, 9, 0, 2'b01, 0, 0, 1, 0);
    cmp("mid_post_sel", int'(sel[1:0]), 0);
    cmp("mid_post_stall", int'(stall), 0);
    cmp("mid_post_cnt", int'(stall_cnt), 0);
    tick();
    // saturation: stall every other cycle, 21 stalls
    drv(1, 10, 0, 2'b01, 1, 10, 2, 0);
    repeat (42) tick();
    drv(1, 0, 0, 2'b00, 0, 0, 1, 0);
    cmp("sat_main_cnt", int'(stall_cnt), 21);
    cmp("sat_cnt_hold", int'(sat_cnt), 15);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
